// File: rtl/descriptor_dispatch.sv
// descriptor_dispatch
//   Takes one descriptor at a time from the frame-parser send stage on a
//   wr/ack handshake. The active wr line picks the destination: host, hcp or
//   network. Each descriptor is queued in that destination's FIFO and drained
//   to its consumer on valid/ready. Consumer back-pressure therefore does not
//   stall the parser until the target FIFO is full.
// Ports
//   clk_sys, reset_n              clock, async active-low reset
//   i_descriptor_wr_to_*          level request, one per destination
//   iv_descriptor[56:0]           descriptor ([8:0] = pkt bufid)
//   i_inverse_map_lookup_flag     side flag stored with network entries
//   o_descriptor_ack              1-cycle accept pulse
//   o_{host,hcp,net}_valid / i_*_ready / ov_*_descriptor   consumer channels
//   o_net_inverse_map_flag        flag paired with ov_net_descriptor
//   o_sel_error                   1-cycle pulse when >1 wr line was high
// Build option
//   DISPATCH_STAT_EN: adds ov_host_cnt/ov_hcp_cnt/ov_net_cnt (accepted writes)
//   and ov_sel_err_cnt (select errors). These are wrapping counters.

module desc_fifo #(
    parameter int DW         = 57,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          i_push,
    input  logic [DW-1:0] iv_din,
    input  logic          i_ready,
    output logic          o_valid,
    output logic          o_full,
    output logic [DW-1:0] ov_dout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][DW-1:0] r_mem;
    logic [PTR_W-1:0]              r_wptr, r_rptr;
    logic [CNT_W-1:0]              r_cnt;
    logic                          w_pop;

    assign o_valid = (r_cnt != '0);
    assign o_full  = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign w_pop   = o_valid & i_ready;
    assign ov_dout = r_mem[r_rptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= iv_din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module descriptor_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        i_descriptor_wr_to_host,
    input  logic        i_descriptor_wr_to_hcp,
    input  logic        i_descriptor_wr_to_network,
    input  logic [56:0] iv_descriptor,
    input  logic        i_inverse_map_lookup_flag,
    output logic        o_descriptor_ack,
    output logic        o_host_valid,
    input  logic        i_host_ready,
    output logic [56:0] ov_host_descriptor,
    output logic        o_hcp_valid,
    input  logic        i_hcp_ready,
    output logic [56:0] ov_hcp_descriptor,
    output logic        o_net_valid,
    input  logic        i_net_ready,
    output logic [56:0] ov_net_descriptor,
    output logic        o_net_inverse_map_flag,
`ifdef DISPATCH_STAT_EN
    output logic [15:0] ov_host_cnt,
    output logic [15:0] ov_hcp_cnt,
    output logic [15:0] ov_net_cnt,
    output logic [7:0]  ov_sel_err_cnt,
`endif
    output logic        o_sel_error
);
    localparam int NCH = 3;  // channel 0 host, 1 hcp, 2 network
    localparam int NET = 2;

    typedef enum logic [0:0] {IDLE, GUARD} state_t;

    state_t                     r_state, w_state_nxt;
    logic                       r_ack, r_err;
    logic                       w_ack_nxt, w_err_nxt;
    logic [NCH-1:0]             w_wr, w_push, w_full, w_valid, w_ready;
    logic [NCH-1:0][56:0]       w_head;
    logic                       w_net_flag;
    logic                       w_onehot, w_multi;

    assign w_wr     = {i_descriptor_wr_to_network, i_descriptor_wr_to_hcp, i_descriptor_wr_to_host};
    assign w_ready  = {i_net_ready, i_hcp_ready, i_host_ready};
    assign w_onehot = (w_wr == 3'b001) || (w_wr == 3'b010) || (w_wr == 3'b100);
    assign w_multi  = (w_wr != '0) && !w_onehot;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // The full check uses the pre-pop count, so a blocked wr simply stays
    // high and retries each IDLE cycle. A multi-select is acked so upstream
    // can drop its lines; otherwise that case would deadlock.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_push      = '0;
        case (r_state)
            IDLE: begin
                if (w_multi) begin
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = GUARD;
                end else if (w_onehot && ((w_wr & ~w_full) != '0)) begin
                    w_push      = w_wr;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = GUARD;
                end
            end
            // Upstream drops wr one edge after seeing ack. Ignore that edge.
            GUARD:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar c = 0; c < NCH; c++) begin : gen_ch
        if (c == NET) begin : gen_net
            logic [57:0] w_q;
            desc_fifo #(.DW(58), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .i_push  (w_push[c]),
                .iv_din  ({i_inverse_map_lookup_flag, iv_descriptor}),
                .i_ready (w_ready[c]),
                .o_valid (w_valid[c]),
                .o_full  (w_full[c]),
                .ov_dout (w_q)
            );
            assign w_head[c]  = w_q[56:0];
            assign w_net_flag = w_q[57];
        end else begin : gen_plain
            desc_fifo #(.DW(57), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .i_push  (w_push[c]),
                .iv_din  (iv_descriptor),
                .i_ready (w_ready[c]),
                .o_valid (w_valid[c]),
                .o_full  (w_full[c]),
                .ov_dout (w_head[c])
            );
        end
    end

    assign o_descriptor_ack       = r_ack;
    assign o_sel_error            = r_err;
    assign o_host_valid           = w_valid[0];
    assign o_hcp_valid            = w_valid[1];
    assign o_net_valid            = w_valid[NET];
    assign ov_host_descriptor     = w_head[0];
    assign ov_hcp_descriptor      = w_head[1];
    assign ov_net_descriptor      = w_head[NET];
    assign o_net_inverse_map_flag = w_net_flag;

`ifdef DISPATCH_STAT_EN
    logic [NCH-1:0][15:0] r_wr_cnt;
    logic [7:0]           r_sel_err_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_cnt      <= '0;
            r_sel_err_cnt <= '0;
        end else begin
            for (int c = 0; c < NCH; c++)
                if (w_push[c]) r_wr_cnt[c] <= r_wr_cnt[c] + 1'b1;
            if (w_err_nxt) r_sel_err_cnt <= r_sel_err_cnt + 1'b1;
        end
    end

    assign ov_host_cnt    = r_wr_cnt[0];
    assign ov_hcp_cnt     = r_wr_cnt[1];
    assign ov_net_cnt     = r_wr_cnt[NET];
    assign ov_sel_err_cnt = r_sel_err_cnt;
`endif
endmodule

// File: tb/tb_descriptor_dispatch.sv
// Scoreboard bench for descriptor_dispatch. Each accepted descriptor is queued
// when it is driven. A negedge monitor pops the queue and compares on every
// consumer handshake.
module tb_descriptor_dispatch;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_host = 0, wr_hcp = 0, wr_net = 0;
    logic [56:0] desc = '0;
    logic        flag = 0;
    logic        ack, host_v, hcp_v, net_v, net_flag, sel_err;
    logic        host_rdy = 0, hcp_rdy = 0, net_rdy = 0;
    logic [56:0] host_d, hcp_d, net_d;
`ifdef DISPATCH_STAT_EN
    logic [15:0] host_cnt, hcp_cnt, net_cnt;
    logic [7:0]  sel_err_cnt;
`endif

    always #5 clk_sys = ~clk_sys;

    descriptor_dispatch dut (
        .clk_sys                    (clk_sys),
        .reset_n                    (reset_n),
        .i_descriptor_wr_to_host    (wr_host),
        .i_descriptor_wr_to_hcp     (wr_hcp),
        .i_descriptor_wr_to_network (wr_net),
        .iv_descriptor              (desc),
        .i_inverse_map_lookup_flag  (flag),
        .o_descriptor_ack           (ack),
        .o_host_valid               (host_v),
        .i_host_ready               (host_rdy),
        .ov_host_descriptor         (host_d),
        .o_hcp_valid                (hcp_v),
        .i_hcp_ready                (hcp_rdy),
        .ov_hcp_descriptor          (hcp_d),
        .o_net_valid                (net_v),
        .i_net_ready                (net_rdy),
        .ov_net_descriptor          (net_d),
        .o_net_inverse_map_flag     (net_flag),
`ifdef DISPATCH_STAT_EN
        .ov_host_cnt                (host_cnt),
        .ov_hcp_cnt                 (hcp_cnt),
        .ov_net_cnt                 (net_cnt),
        .ov_sel_err_cnt             (sel_err_cnt),
`endif
        .o_sel_error                (sel_err)
    );

    int n_chk = 0, n_pass = 0, n_host_pop = 0;
    logic [57:0] q_host[$], q_hcp[$], q_net[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // consumer-side scoreboard
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (host_v && host_rdy) begin
                n_host_pop++;
                if (q_host.size() == 0) chk("host_unexp", q_host.size(), 1);
                else chk("host_data", {1'b0, host_d}, q_host.pop_front());
            end
            if (hcp_v && hcp_rdy) begin
                if (q_hcp.size() == 0) chk("hcp_unexp", q_hcp.size(), 1);
                else chk("hcp_data", {1'b0, hcp_d}, q_hcp.pop_front());
            end
            if (net_v && net_rdy) begin
                if (q_net.size() == 0) chk("net_unexp", q_net.size(), 1);
                else chk("net_data", {net_flag, net_d}, q_net.pop_front());
            end
        end
    end

    task automatic drive(input int ch, input logic [56:0] d, input logic f, input bit exp_push);
        desc    = d;
        flag    = f;
        wr_host = (ch == 0);
        wr_hcp  = (ch == 1);
        wr_net  = (ch == 2);
        if (exp_push) begin
            if (ch == 0) q_host.push_back({1'b0, d});
            if (ch == 1) q_hcp.push_back({1'b0, d});
            if (ch == 2) q_net.push_back({f, d});
        end
    endtask

    task automatic wait_ack(input string tag);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_sys);
            if (ack) got = 1;
        end
        chk(tag, got, 1);
    endtask

    // drop wr on the edge after ack, then confirm ack was a single pulse
    task automatic release_wr();
        @(posedge clk_sys); #1;
        wr_host = 0; wr_hcp = 0; wr_net = 0;
        @(negedge clk_sys);
        chk("ack_pulse", ack, 0);
    endtask

    task automatic send(input int ch, input logic [56:0] d, input logic f);
        @(posedge clk_sys); #1;
        drive(ch, d, f, 1);
        wait_ack("ack");
        release_wr();
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk_sys);
            done = (q_host.size() == 0) && (q_hcp.size() == 0) && (q_net.size() == 0);
        end
        chk("drain", done, 1);
    endtask

    initial begin
        int acks, p0;
        // reset state
        #3;
        chk("rst_ack", ack, 0);
        chk("rst_valids", {host_v, hcp_v, net_v}, 0);
        chk("rst_err", sel_err, 0);
        chk("rst_net_d", {net_flag, net_d}, 0);
        #20 reset_n = 1;

        // single host descriptor; it is visible on the same cycle as ack
        host_rdy = 1; hcp_rdy = 1; net_rdy = 1;
        @(posedge clk_sys); #1;
        drive(0, 57'h0AB_CDEF_0123_4017, 0, 1);
        wait_ack("host_ack");
        chk("host_lat_valid", host_v, 1);
        chk("host_idle_others", {hcp_v, net_v}, 0);
        release_wr();
        drain();

        // network back-pressure: 4 fit, 5th waits until one pop
        net_rdy = 0;
        for (int i = 0; i < 4; i++) send(2, 57'h1_0000_0000_0100 + 57'(i), 1'(i % 2 == 0));
        @(posedge clk_sys); #1;
        drive(2, 57'h1_0000_0000_0104, 1, 1);
        acks = 0;
        repeat (6) begin @(negedge clk_sys); if (ack) acks++; end
        chk("net_full_noack", acks, 0);
        chk("net_full_valid", net_v, 1);
        @(posedge clk_sys); #1 net_rdy = 1;
        @(posedge clk_sys); #1 net_rdy = 0;
        wait_ack("net5_ack");
        release_wr();
        net_rdy = 1;
        drain();

        // wr still high across the guard edge must not be accepted again
        p0 = n_host_pop;
        @(posedge clk_sys); #1;
        drive(0, 57'h0_0000_0000_01AA, 0, 1);
        acks = 0;
        repeat (2) begin @(negedge clk_sys); if (ack) acks++; end
        @(posedge clk_sys); #1 wr_host = 0;
        repeat (10) begin @(negedge clk_sys); if (ack) acks++; end
        chk("guard_acks", acks, 1);
        chk("guard_entries", n_host_pop - p0, 1);

        // two wr lines: ack + sel_error, no FIFO writes
        @(posedge clk_sys); #1;
        desc = 57'h1FF; wr_hcp = 1; wr_net = 1;
        wait_ack("sel_ack");
        chk("sel_err_pulse", sel_err, 1);
        release_wr();
        chk("sel_err_low", sel_err, 0);
        chk("sel_no_write", {hcp_v, net_v}, 0);
`ifdef DISPATCH_STAT_EN
        chk("stat_sel_err", sel_err_cnt, 1);
        chk("stat_host", host_cnt, 2);
        chk("stat_net", net_cnt, 5);
        chk("stat_hcp", hcp_cnt, 0);
`endif

        // hcp: advance pointers, then a same-cycle push/pop at count 3
        for (int i = 0; i < 3; i++) send(1, 57'h0_2000_0000_0000 + 57'(i), 0);
        drain();
        hcp_rdy = 0;
        for (int i = 0; i < 3; i++) send(1, 57'h0_3000_0000_0010 + 57'(i), 0);
        @(posedge clk_sys); #1;
        drive(1, 57'h0_3000_0000_0013, 0, 1);
        hcp_rdy = 1;
        @(posedge clk_sys); #1 hcp_rdy = 0;
        wait_ack("hcp_wp_ack");
        release_wr();
        send(1, 57'h0_3000_0000_0014, 0);   // count 3 -> 4
        @(posedge clk_sys); #1;
        drive(1, 57'h0_3000_0000_00FF, 0, 0);
        acks = 0;
        repeat (5) begin @(negedge clk_sys); if (ack) acks++; end
        chk("hcp_full_noack", acks, 0);
        @(posedge clk_sys); #1 wr_hcp = 0;
        hcp_rdy = 1;
        drain();

        // async reset with entries queued and ack high
        host_rdy = 0;
        send(0, 57'h0_4000_0000_0001, 0);
        send(0, 57'h0_4000_0000_0002, 0);
        @(posedge clk_sys); #1;
        drive(0, 57'h0_4000_0000_0003, 0, 0);
        wait_ack("rst_pre_ack");
        reset_n = 0;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_valids", {host_v, hcp_v, net_v}, 0);
        chk("mid_rst_head", host_d, 0);
        wr_host = 0;
        q_host.delete(); q_hcp.delete(); q_net.delete();
        #20 reset_n = 1;
        host_rdy = 1;
        send(0, 57'h0_5000_0000_0055, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
